// File: rtl/tpu_sync_fifo_if.sv
// Handshake/data bundle for tpu_sync_fifo: producer/consumer requests and the
// queue status outputs. Port names match the original flat port list.
interface tpu_sync_fifo_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              i_clr;
    logic              i_wr;
    logic [DATA_W-1:0] i_data;
    logic              i_rd;
    logic [DATA_W-1:0] o_data;
    logic              o_full;
    logic              o_empty;
    logic              o_almost_full;
    logic              o_almost_empty;
    logic [CW-1:0]     o_count;
    logic              o_overflow;
    logic              o_underflow;

    modport master (
        output i_clr, i_wr, i_data, i_rd,
        input  o_data, o_full, o_empty, o_almost_full, o_almost_empty,
               o_count, o_overflow, o_underflow
    );

    modport slave (
        input  i_clr, i_wr, i_data, i_rd,
        output o_data, o_full, o_empty, o_almost_full, o_almost_empty,
               o_count, o_overflow, o_underflow
    );
endinterface

// File: rtl/tpu_sync_fifo.sv
// Single-clock show-ahead FIFO with wrap-bit pointers, registered occupancy,
// almost-full/empty thresholds, sticky overflow/underflow and synchronous flush.
module tpu_sync_fifo #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    tpu_sync_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic full, empty, wr_acc, rd_acc;

    // Flags come only from registered state, never from this cycle's requests.
    assign full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign wr_acc = bus.i_wr && !full  && !bus.i_clr;
    assign rd_acc = bus.i_rd && !empty && !bus.i_clr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (bus.i_wr && full);
        unf_d    = unf_q | (bus.i_rd && empty);
        if (bus.i_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
            if (wr_acc && !rd_acc)      count_d = count_q + PW'(1);
            else if (rd_acc && !wr_acc) count_d = count_q - PW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is deliberately unreset so it can map onto RAM.
    always_ff @(posedge i_clk) begin
        if (wr_acc) mem[wr_ptr_q[AW-1:0]] <= bus.i_data;
    end

    assign bus.o_data         = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
    assign bus.o_full         = full;
    assign bus.o_empty        = empty;
    assign bus.o_almost_full  = (count_q >= PW'(AF_LEVEL));
    assign bus.o_almost_empty = (count_q <= PW'(AE_LEVEL));
    assign bus.o_count        = count_q;
    assign bus.o_overflow     = ovf_q;
    assign bus.o_underflow    = unf_q;
endmodule

// File: tb/tb_tpu_sync_fifo.sv
// Directed bench for tpu_sync_fifo: stimulus pushes expected pop data into a
// scoreboard queue, a negedge monitor compares every accepted read.
module tb_tpu_sync_fifo;
    logic clk;
    logic rstn;
    int unsigned n_cmp;
    int unsigned n_bad;
    logic [31:0] sb [$];

    tpu_sync_fifo_if #(.DATA_W(32), .DEPTH(8)) bus ();

    tpu_sync_fifo #(
        .DATA_W  (32),
        .DEPTH   (8),
        .AF_LEVEL(6),
        .AE_LEVEL(2)
    ) u_dut (
        .i_clk (clk),
        .i_rstn(rstn),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: an accepted read pops the next expected word.
    initial begin
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            if (rstn && bus.i_rd && !bus.o_empty && !bus.i_clr) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL pop_unexpected: got 0x%0h expected no read at %0t", bus.o_data, $time);
                end else begin
                    exp = sb.pop_front();
                    check("pop_data", bus.o_data, exp);
                end
            end
        end
    end

    // Drive one cycle of requests (called just after a rising edge).
    task automatic cyc(input logic wr, input logic rd, input logic clr, input logic [31:0] d);
        bus.i_wr   = wr;
        bus.i_rd   = rd;
        bus.i_clr  = clr;
        bus.i_data = d;
        @(posedge clk);
        #1;
        bus.i_wr  = 1'b0;
        bus.i_rd  = 1'b0;
        bus.i_clr = 1'b0;
    endtask

    task automatic wr_push(input logic [31:0] d);
        sb.push_back(d);
        cyc(1'b1, 1'b0, 1'b0, d);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_count"},  32'(bus.o_count), 32'd0);
        check({tag, "_empty"},  32'(bus.o_empty), 32'd1);
        check({tag, "_full"},   32'(bus.o_full), 32'd0);
        check({tag, "_ae"},     32'(bus.o_almost_empty), 32'd1);
        check({tag, "_af"},     32'(bus.o_almost_full), 32'd0);
        check({tag, "_ovf"},    32'(bus.o_overflow), 32'd0);
        check({tag, "_unf"},    32'(bus.o_underflow), 32'd0);
        check({tag, "_data"},   bus.o_data, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rstn = 1'b0;
        bus.i_wr = 1'b0; bus.i_rd = 1'b0; bus.i_clr = 1'b0; bus.i_data = '0;
        #12;
        check_reset_vals("rst");
        rstn = 1'b1;
        @(posedge clk); #1;

        // Fill with 0x10..0x17; head stays 0x10, almost_full from count 6.
        for (int i = 0; i < 8; i++) begin
            wr_push(32'h10 + 32'(i));
            check("fill_count", 32'(bus.o_count), 32'(i + 1));
            check("fill_af",    32'(bus.o_almost_full), (i + 1 >= 6) ? 32'd1 : 32'd0);
            check("fill_full",  32'(bus.o_full), (i == 7) ? 32'd1 : 32'd0);
            check("fill_head",  bus.o_data, 32'h10);
        end

        // Full: write+read pops 0x10, drops 0x99.
        cyc(1'b1, 1'b1, 1'b0, 32'h99);
        check("ovf_count", 32'(bus.o_count), 32'd7);
        check("ovf_flag",  32'(bus.o_overflow), 32'd1);
        check("ovf_full",  32'(bus.o_full), 32'd0);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("drain_empty", 32'(bus.o_empty), 32'd1);
        check("drain_data",  bus.o_data, 32'd0);
        check("drain_count", 32'(bus.o_count), 32'd0);

        // Streaming at count 3 with pointer wrap.
        for (int i = 0; i < 3; i++) wr_push(32'h20 + 32'(i));
        for (int i = 0; i < 20; i++) begin
            sb.push_back(32'h30 + 32'(i));
            cyc(1'b1, 1'b1, 1'b0, 32'h30 + 32'(i));
            check("stream_count", 32'(bus.o_count), 32'd3);
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("stream_empty", 32'(bus.o_empty), 32'd1);

        // Empty: read+write -> underflow, write lands.
        sb.push_back(32'hA5);
        cyc(1'b1, 1'b1, 1'b0, 32'hA5);
        check("unf_flag",  32'(bus.o_underflow), 32'd1);
        check("unf_count", 32'(bus.o_count), 32'd1);
        check("unf_data",  bus.o_data, 32'hA5);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("unf_sticky", 32'(bus.o_underflow), 32'd1);

        // Count 5 with overflow set, then clear with a write.
        for (int i = 0; i < 8; i++) wr_push(32'h40 + 32'(i));
        cyc(1'b1, 1'b0, 1'b0, 32'hDD);
        check("ovf2_flag", 32'(bus.o_overflow), 32'd1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("pre_clr_count", 32'(bus.o_count), 32'd5);
        cyc(1'b1, 1'b0, 1'b1, 32'hEE);
        sb.delete();
        check("clr_count", 32'(bus.o_count), 32'd0);
        check("clr_empty", 32'(bus.o_empty), 32'd1);
        check("clr_ovf",   32'(bus.o_overflow), 32'd0);
        check("clr_unf",   32'(bus.o_underflow), 32'd0);
        check("clr_data",  bus.o_data, 32'd0);

        // Async reset mid-cycle at count 4.
        for (int i = 0; i < 4; i++) wr_push(32'h50 + 32'(i));
        check("pre_rst_count", 32'(bus.o_count), 32'd4);
        rstn = 1'b0;
        #2;
        check_reset_vals("async");
        sb.delete();
        #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        wr_push(32'h1);
        check("post_rst_data",  bus.o_data, 32'h1);
        check("post_rst_count", 32'(bus.o_count), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        check("final_empty", 32'(bus.o_empty), 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
